// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared sizes and source encoding for the write-back port arbiter
package wb_port_arbiter_pkg;
  localparam int WB_DATA_W   = 64;
  localparam int WB_ADDR_W   = 5;
  localparam int WB_NUM_REGS = 32;
  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;
  // MEM as the reset history makes ALU win the first tie after reset
  localparam src_e LAST_GRANT_RST = SRC_MEM;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending bits, set on issue and cleared on write-back accept
module wb_scoreboard
  import wb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int NUM_REGS = WB_NUM_REGS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_set,
  input  logic [ADDR_W-1:0]   i_set_rd,
  input  logic                i_clr,
  input  logic [ADDR_W-1:0]   i_clr_rd,
  output logic [NUM_REGS-1:0] o_pending
);
  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;
  assign w_set = (i_set && i_set_rd != '0) ? NUM_REGS'(1) << i_set_rd : '0;
  assign w_clr = (i_clr && i_clr_rd != '0) ? NUM_REGS'(1) << i_clr_rd : '0;
  // set applied after clear: a newer producer for the same rd stays outstanding
  always_ff @(posedge clk) begin
    if (!rst_n) r_pending <= '0;
    else r_pending <= (r_pending & ~w_clr) | w_set;
  end
  assign o_pending = r_pending;
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: round-robin ALU/load arbiter driving the single register-file write port
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int DATA_W   = WB_DATA_W,
  parameter int ADDR_W   = WB_ADDR_W,
  parameter int NUM_REGS = WB_NUM_REGS,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                alu_valid,
  input  logic [ADDR_W-1:0]   alu_rd,
  input  logic [DATA_W-1:0]   alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [ADDR_W-1:0]   mem_rd,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                mem_ready,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rd,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    wr_count
);
  src_e              r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_gnt_alu;
  logic              w_gnt_mem;
  logic              w_acc;
  logic              w_commit;
  logic [ADDR_W-1:0] w_rd;
  logic [DATA_W-1:0] w_data;
  assign w_gnt_alu = rst_n && alu_valid && (!mem_valid || r_last == SRC_MEM);
  assign w_gnt_mem = rst_n && mem_valid && (!alu_valid || r_last == SRC_ALU);
  assign w_acc     = w_gnt_alu || w_gnt_mem;
  assign w_rd      = w_gnt_alu ? alu_rd : mem_rd;
  assign w_data    = w_gnt_alu ? alu_data : mem_data;
  // x0 writes are consumed for flow control but never reach the register file
  assign w_commit  = w_acc && (w_rd != '0);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_last  <= LAST_GRANT_RST;
    end else begin
      r_we <= w_commit;
      if (w_commit) begin
        r_waddr <= w_rd;
        r_wdata <= w_data;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_acc) r_last <= w_gnt_alu ? SRC_ALU : SRC_MEM;
    end
  end
  wb_scoreboard #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_set    (iss_valid),
    .i_set_rd (iss_rd),
    .i_clr    (w_acc),
    .i_clr_rd (w_rd),
    .o_pending(pending)
  );
  assign alu_ready = w_gnt_alu;
  assign mem_ready = w_gnt_mem;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign wr_count  = r_cnt;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random checks against a behavioural write-back model
module tb_wb_port_arbiter;
  localparam int AW = 5, DW = 64, NR = 32, CW = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic alu_valid, mem_valid, iss_valid;
  logic [AW-1:0] alu_rd, mem_rd, iss_rd;
  logic [DW-1:0] alu_data, mem_data;
  logic alu_ready, mem_ready, rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] pending;
  logic [CW-1:0] wr_count;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending(pending), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // model: last winner name, pending set as a bit array, written-register history
  string m_last = "MEM";
  bit m_pend[NR];
  bit m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int m_cnt;
  bit e_alu, e_mem;
  logic o_alu, o_mem;
  int n_chk = 0, n_pass = 0;

  function automatic logic [NR-1:0] pend_vec();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic tick();
    int rd;
    logic [DW-1:0] d;
    #1;
    e_alu = 0; e_mem = 0;
    if (rst_n) begin
      if (alu_valid && !mem_valid) e_alu = 1;
      else if (mem_valid && !alu_valid) e_mem = 1;
      else if (alu_valid && mem_valid) begin
        if (m_last == "ALU") e_mem = 1; else e_alu = 1;
      end
    end
    o_alu = alu_ready;
    o_mem = mem_ready;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_last = "MEM"; m_we = 0; m_waddr = '0; m_wdata = '0; m_cnt = 0;
      for (int i = 0; i < NR; i++) m_pend[i] = 0;
    end else begin
      m_we = 0;
      if (e_alu || e_mem) begin
        rd = e_alu ? int'(alu_rd) : int'(mem_rd);
        d  = e_alu ? alu_data : mem_data;
        m_last = e_alu ? "ALU" : "MEM";
        if (rd != 0) begin
          m_pend[rd] = 0;
          m_we = 1; m_waddr = AW'(rd); m_wdata = d;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end
      if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1;
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; mem_valid = 0; iss_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    alu_valid = 1; alu_rd = 3; alu_data = 64'hA5;
    mem_valid = 1; mem_rd = 5; mem_data = 64'h5A;
    iss_valid = 0; iss_rd = 0;
    repeat (2) tick();
    n_chk++;
    if (o_alu !== 1'b0 || o_mem !== 1'b0) $display("FAIL reset_ready got %b%b want 00", o_alu, o_mem);
    else n_pass++;
    n_chk++;
    if ({rf_we, rf_waddr, rf_wdata, pending, wr_count} !== '0)
      $display("FAIL reset_state got we=%b a=%0d d=%h p=%h c=%0d want all 0", rf_we, rf_waddr, rf_wdata, pending, wr_count);
    else n_pass++;
    rst_n = 1;
    tick();
    n_chk++;
    if (o_alu !== 1'b1 || o_mem !== 1'b0) $display("FAIL first_grant got alu=%b mem=%b want 1 0", o_alu, o_mem);
    else n_pass++;
    n_chk++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 64'hA5)
      $display("FAIL first_write got we=%b a=%0d d=%h want 1 3 a5", rf_we, rf_waddr, rf_wdata);
    else n_pass++;
    alu_valid = 0;
    tick();
    mem_valid = 0;
    n_chk++;
    if (o_mem !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 64'h5A || wr_count !== 4'd2)
      $display("FAIL mem_after_alu got rdy=%b a=%0d d=%h c=%0d want 1 5 5a 2", o_mem, rf_waddr, rf_wdata, wr_count);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int ai = 0, mi = 0, c0 = m_cnt;
    bit want_alu;
    alu_valid = 1; mem_valid = 1;
    for (int i = 0; i < 4; i++) begin
      alu_rd = AW'(1 + ai); alu_data = DW'(100 + ai);
      mem_rd = AW'(5 + mi); mem_data = DW'(200 + mi);
      tick();
      want_alu = (i % 2 == 0);
      n_chk++;
      if (o_alu !== want_alu || o_mem !== !want_alu)
        $display("FAIL rr_grant[%0d] got alu=%b mem=%b want alu=%b", i, o_alu, o_mem, want_alu);
      else n_pass++;
      n_chk++;
      if (rf_we !== 1'b1 || rf_waddr !== AW'(want_alu ? 1 + i / 2 : 5 + i / 2))
        $display("FAIL rr_write[%0d] got we=%b a=%0d want 1 %0d", i, rf_we, rf_waddr, want_alu ? 1 + i / 2 : 5 + i / 2);
      else n_pass++;
      if (o_alu) ai++;
      if (o_mem) mi++;
    end
    idle_inputs();
    n_chk++;
    if (wr_count !== CW'((c0 + 4) % 16)) $display("FAIL rr_count got %0d want %0d", wr_count, (c0 + 4) % 16);
    else n_pass++;
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_rd = 7;
    tick();
    iss_valid = 0;
    n_chk++;
    if (pending[7] !== 1'b1) $display("FAIL sb_set got %b want 1", pending[7]);
    else n_pass++;
    mem_valid = 1; mem_rd = 7; mem_data = 64'h77;
    tick();
    mem_valid = 0;
    n_chk++;
    if (o_mem !== 1'b1 || pending[7] !== 1'b0 || pending !== pend_vec())
      $display("FAIL sb_clear got rdy=%b p=%h want 1 %h", o_mem, pending, pend_vec());
    else n_pass++;
  endtask

  task automatic test_set_wins();
    iss_valid = 1; iss_rd = 9;
    tick();
    alu_valid = 1; alu_rd = 9; alu_data = 64'h99;
    tick();
    idle_inputs();
    n_chk++;
    if (o_alu !== 1'b1 || pending[9] !== 1'b1 || rf_we !== 1'b1 || rf_waddr !== 5'd9)
      $display("FAIL set_wins got rdy=%b p9=%b we=%b a=%0d want 1 1 1 9", o_alu, pending[9], rf_we, rf_waddr);
    else n_pass++;
  endtask

  task automatic test_x0();
    int c0 = m_cnt;
    alu_valid = 1; alu_rd = 0; alu_data = 64'hFF;
    iss_valid = 1; iss_rd = 0;
    tick();
    idle_inputs();
    n_chk++;
    if (o_alu !== 1'b1 || rf_we !== 1'b0 || wr_count !== CW'(c0))
      $display("FAIL x0_write got rdy=%b we=%b c=%0d want 1 0 %0d", o_alu, rf_we, wr_count, c0);
    else n_pass++;
    n_chk++;
    if (pending[0] !== 1'b0 || pending !== pend_vec()) $display("FAIL x0_pending got %h want %h", pending, pend_vec());
    else n_pass++;
    alu_valid = 1; alu_rd = 10; alu_data = 64'h10;
    mem_valid = 1; mem_rd = 11; mem_data = 64'h11;
    tick();
    idle_inputs();
    n_chk++;
    if (o_mem !== 1'b1 || o_alu !== 1'b0 || rf_waddr !== 5'd11)
      $display("FAIL x0_rr got alu=%b mem=%b a=%0d want 0 1 11", o_alu, o_mem, rf_waddr);
    else n_pass++;
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 40 && m_cnt != 15; k++) begin
      alu_valid = 1; alu_rd = 2; alu_data = DW'(k);
      tick();
    end
    alu_valid = 0;
    n_chk++;
    if (wr_count !== 4'd15) $display("FAIL wrap_pre got %0d want 15", wr_count);
    else n_pass++;
    alu_valid = 1; alu_rd = 4; alu_data = 64'h44;
    tick();
    alu_valid = 0;
    n_chk++;
    if (wr_count !== 4'd0) $display("FAIL wrap got %0d want 0", wr_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    iss_valid = 1; iss_rd = 12;
    tick();
    iss_valid = 0;
    alu_valid = 1; alu_rd = 13; alu_data = 64'h13;
    mem_valid = 1; mem_rd = 14; mem_data = 64'h14;
    tick();
    n_chk++;
    if (rf_we !== 1'b1 || pending[12] !== 1'b1) $display("FAIL pre_reset got we=%b p12=%b want 1 1", rf_we, pending[12]);
    else n_pass++;
    rst_n = 0;
    tick();
    n_chk++;
    if (o_alu !== 1'b0 || o_mem !== 1'b0 || rf_we !== 1'b0 || pending !== '0 || wr_count !== '0)
      $display("FAIL mid_reset got rdy=%b%b we=%b p=%h c=%0d want 00 0 0 0", o_alu, o_mem, rf_we, pending, wr_count);
    else n_pass++;
    rst_n = 1;
    tick();
    idle_inputs();
    n_chk++;
    if (o_alu !== 1'b1 || o_mem !== 1'b0) $display("FAIL post_reset_grant got alu=%b mem=%b want 1 0", o_alu, o_mem);
    else n_pass++;
  endtask

  task automatic test_random();
    bit a_hold = 0, m_hold = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!a_hold) begin
        alu_valid = $urandom_range(0, 2) != 0; alu_rd = AW'($urandom); alu_data = {$urandom, $urandom};
      end
      if (!m_hold) begin
        mem_valid = $urandom_range(0, 2) != 0; mem_rd = AW'($urandom); mem_data = {$urandom, $urandom};
      end
      iss_valid = $urandom_range(0, 1) == 1;
      iss_rd = AW'($urandom);
      rst_n = $urandom_range(0, 60) != 0;
      tick();
      n_chk++;
      if (o_alu !== e_alu || o_mem !== e_mem || (o_alu && o_mem))
        $display("FAIL rand_ready[%0d] got %b%b want %b%b", cyc, o_alu, o_mem, e_alu, e_mem);
      else n_pass++;
      n_chk++;
      if ({rf_we, rf_waddr, rf_wdata, pending, wr_count} !== {m_we, m_waddr, m_wdata, pend_vec(), CW'(m_cnt)})
        $display("FAIL rand_state[%0d] got we=%b a=%0d d=%h p=%h c=%0d want %b %0d %h %h %0d", cyc,
                 rf_we, rf_waddr, rf_wdata, pending, wr_count, m_we, m_waddr, m_wdata, pend_vec(), m_cnt);
      else n_pass++;
      a_hold = alu_valid && !o_alu;
      m_hold = mem_valid && !o_mem;
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    rst_n = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    mem_valid = 0; mem_rd = 0; mem_data = 0;
    iss_valid = 0; iss_rd = 0;
    test_reset();
    test_round_robin();
    test_scoreboard();
    test_set_wins();
    test_x0();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Single-write-port controller for the 32x64 register file at the write-back end of the pipeline. It arbitrates between two write-back producers (ALU path, load path) using round-robin, registers the winning write onto the register-file port, and keeps a per-register pending scoreboard. Decode uses the scoreboard for RAW stall detection. It also keeps a committed-write counter for performance and debug.

Parameters:
DATA_W, 64, register data width
ADDR_W, 5, register index width
NUM_REGS, 32, register count (2**ADDR_W)
CNT_W, 16, committed-write counter width

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous, active-low reset
alu_valid  in  1  ALU result available
alu_rd  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU result accepted this cycle
mem_valid  in  1  load data available
mem_rd  in  ADDR_W  load destination register
mem_data  in  DATA_W  load data
mem_ready  out  1  load accepted this cycle
iss_valid  in  1  instruction with destination issued from decode
iss_rd  in  ADDR_W  issued destination register
rf_we  out  1  register-file write enable (registered)
rf_waddr  out  ADDR_W  register-file write address (registered)
rf_wdata  out  DATA_W  register-file write data (registered)
pending  out  NUM_REGS  bit i = register i awaiting write-back
wr_count  out  CNT_W  number of committed non-x0 writes

Behaviour:
- Reset: sampled only on a clk edge with rst_n=0. Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, wr_count=0, last_grant=MEM. A reset mid-transfer drops any in-flight write: rf_we=0 on the following cycle.
- Grant (combinational from valid signals and last_grant):
  - Only alu_valid: grant ALU.
  - Only mem_valid: grant MEM.
  - Both valid: grant the source that is not last_grant.
  - Neither valid: no grant.
- alu_ready / mem_ready equal the grant. At most one is high per cycle. Both are 0 while rst_n=0.
- Handshake: a transfer happens when valid && ready. A producer holds valid, rd and data stable until accepted. The non-granted producer waits.
- last_grant updates only on an accepted transfer.
- Write latency is 1 cycle: acceptance in cycle N gives rf_we=1 with rd/data in cycle N+1. With no accept, rf_we=0 and addr/data hold their previous values.
- x0: a transfer with rd=0 is accepted normally (ready asserted, round-robin advances), but rf_we stays 0 and wr_count does not increment.
- Sustained throughput: one write per cycle. With both producers continuously valid, grants alternate ALU, MEM, ALU, and so on. ALU is granted first after reset.
- Scoreboard, updated per cycle:
  - Set: iss_valid && iss_rd!=0 sets pending[iss_rd].
  - Clear: an accepted transfer with rd!=0 clears pending[rd] (clear at accept, i.e. cycle N, visible in N+1).
  - Same-cycle set and clear of the same rd: set wins (a newer producer is outstanding).
  - Set and clear on different rd: both apply.
  - pending[0] is always 0.
- wr_count: increments by 1 per accepted rd!=0 transfer and wraps from 2**CNT_W-1 to 0 with no flag.
- Producers are not required to have a pending bit set. An accept on a non-pending rd simply leaves that bit 0; no error is raised.

Decomposition:
- Shared package: source enum (SRC_ALU=0, SRC_MEM=1), DATA_W/ADDR_W/NUM_REGS constants, and the reset value of last_grant.
- One sub-module, wb_scoreboard: the pending vector with set/clear/priority logic, instantiated once.
- Arbiter, output register and counter stay in the top block.

Test Plan:
- Reset with alu_valid=mem_valid=1 held -> no ready while rst_n=0. After release, first grant is ALU (rd=3, data=0xA5), rf_we=1 with waddr=3, wdata=0xA5 one cycle later.
- Both valid for 4 cycles (ALU rd=1..4, MEM rd=5..8, held until accepted) -> grant order ALU1, MEM5, ALU2, MEM6. rf_we=1 every cycle. wr_count=4 after the 4th write.
- iss_valid rd=7 -> pending[7]=1 next cycle. MEM write rd=7 accepted -> pending[7]=0 the following cycle.
- Same cycle: iss_rd=9 and accepted ALU write rd=9, with pending[9] previously 1 -> pending[9] stays 1.
- ALU write rd=0 data=0xFF accepted -> alu_ready=1, rf_we=0, wr_count unchanged, next tie goes to MEM. iss_rd=0 -> pending stays 0.
- wr_count preloaded near wrap (CNT_W=4, 15 writes then 1 more) -> reads 15 then 0. Assert rst_n=0 the cycle after an accept -> rf_we=0, pending=0, wr_count=0.
